// File: rtl/vector_alu_mc_pkg.sv
// vector_alu_pkg: op codes, FSM states, AES S-box tables and GF(2^8) helpers shared by the vector ALU.
package vector_alu_pkg;
  typedef enum logic [3:0] {
    OP_XOR             = 4'b0000,
    OP_ROT             = 4'b0001,
    OP_SUBBYTES        = 4'b1000,
    OP_SHIFTROWS       = 4'b1001,
    OP_MIX_COLUMNS     = 4'b1010,
    OP_KEYSCHE_XOR     = 4'b1011,
    OP_INV_SUBBYTES    = 4'b1100,
    OP_INV_SHIFTROWS   = 4'b1101,
    OP_INV_MIX_COLUMNS = 4'b1110
  } valu_op;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d};
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
endpackage

// File: rtl/vector_alu_mc_if.sv
// vector_alu_mc_if: request/response bus of the multicycle vector ALU.
interface vector_alu_mc_if #(parameter int NUM_LANES = 1);
  localparam int W = 128 * NUM_LANES;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_control;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         illegal_op;
  logic         busy;
  modport master (output in_valid, alu_control, op1, op2, out_ready,
                  input in_ready, out_valid, result, illegal_op, busy);
  modport slave (input in_valid, alu_control, op1, op2, out_ready,
                 output in_ready, out_valid, result, illegal_op, busy);
endinterface

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES byte substitution; inv selects the inverse table.
module aes_sbox
  import vector_alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic       inv,
  output logic [7:0] y
);
  assign y = inv ? INV_SBOX[a] : SBOX[a];
endmodule

// File: rtl/vector_alu_mc.sv
// vector_alu_mc: multicycle NUM_LANES x 128-bit AES round-primitive ALU; VALU_INV_EN adds inverse ops.
module vector_alu_mc
  import vector_alu_pkg::*;
#(
  parameter int NUM_LANES      = 1,
  parameter int SBOX_PER_CYCLE = 16
) (
  input logic            clk,
  input logic            rst_n,
  vector_alu_mc_if.slave bus
);
  localparam int W    = 128 * NUM_LANES;
  localparam int S    = SBOX_PER_CYCLE;
  localparam int ITER = 16 / S;
  localparam int CW   = ITER > 1 ? $clog2(ITER) : 1;
  if (S != 1 && S != 2 && S != 4 && S != 8 && S != 16) begin : g_bad_sbox
    $error("SBOX_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end
  state_e           state, state_n;
  valu_op           op_q;
  logic [W-1:0]     a_q, b_q, r_q, res_n, sb_res;
  logic             ill_q, ill_n, inv_sel, is_sb, last, accept;
  logic [CW-1:0]    cnt;
  logic [W*S/16-1:0] sb_out;
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[i*8 +: 8] = s[(inv ? (i + 16 - 4 * (i % 4)) % 16 : (i + 4 * (i % 4)) % 16) * 8 +: 8];
    return o;
  endfunction
  function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [31:0]  m;
    m = inv ? 32'h090d0b0e : 32'h01010302;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        for (int j = 0; j < 4; j++)
          o[(4*c+r)*8 +: 8] ^= gf_mul(m[j*8 +: 8], s[(4*c + (r+j) % 4)*8 +: 8]);
    return o;
  endfunction
  function automatic logic [127:0] key_xor(input logic [127:0] k, input logic [31:0] t);
    logic [127:0] o;
    logic [31:0]  w;
    w = t;
    for (int j = 0; j < 4; j++) begin
      w = w ^ k[j*32 +: 32];
      o[j*32 +: 32] = w;
    end
    return o;
  endfunction
  function automatic logic [127:0] rot_words(input logic [127:0] k);
    logic [127:0] o;
    for (int j = 0; j < 4; j++) o[j*32 +: 32] = {k[j*32 +: 8], k[j*32+8 +: 24]};
    return o;
  endfunction
  assign accept = bus.in_valid && state == IDLE;
`ifdef VALU_INV_EN
  assign inv_sel = op_q == OP_INV_SUBBYTES;
`else
  assign inv_sel = 1'b0;
`endif
  assign is_sb          = op_q == OP_SUBBYTES || inv_sel;
  assign last           = cnt == CW'(ITER - 1);
  assign bus.result     = r_q;
  assign bus.illegal_op = ill_q;
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    for (genvar k = 0; k < S; k++) begin : g_sb
      aes_sbox u_sbox (
        .a  (a_q[l*128 + (int'(cnt)*S + k)*8 +: 8]),
        .inv(inv_sel),
        .y  (sb_out[(l*S + k)*8 +: 8])
      );
    end
  end
  // SubBytes rewrites only the S-byte slice selected by the iteration counter
  always_comb begin
    sb_res = r_q;
    for (int l = 0; l < NUM_LANES; l++)
      for (int k = 0; k < S; k++)
        sb_res[l*128 + (int'(cnt)*S + k)*8 +: 8] = sb_out[(l*S + k)*8 +: 8];
  end
  always_comb begin
    res_n = r_q;
    ill_n = 1'b0;
    for (int l = 0; l < NUM_LANES; l++)
      case (op_q)
        OP_XOR:             res_n[l*128 +: 128] = a_q[l*128 +: 128] ^ b_q[l*128 +: 128];
        OP_ROT:             res_n[l*128 +: 128] = rot_words(a_q[l*128 +: 128]);
        OP_SUBBYTES:        res_n[l*128 +: 128] = sb_res[l*128 +: 128];
        OP_SHIFTROWS:       res_n[l*128 +: 128] = shift_rows(a_q[l*128 +: 128], 1'b0);
        OP_MIX_COLUMNS:     res_n[l*128 +: 128] = mix_cols(a_q[l*128 +: 128], 1'b0);
        OP_KEYSCHE_XOR:     res_n[l*128 +: 128] = key_xor(a_q[l*128 +: 128], b_q[l*128 +: 32]);
`ifdef VALU_INV_EN
        OP_INV_SUBBYTES:    res_n[l*128 +: 128] = sb_res[l*128 +: 128];
        OP_INV_SHIFTROWS:   res_n[l*128 +: 128] = shift_rows(a_q[l*128 +: 128], 1'b1);
        OP_INV_MIX_COLUMNS: res_n[l*128 +: 128] = mix_cols(a_q[l*128 +: 128], 1'b1);
`endif
        default: begin
          res_n[l*128 +: 128] = '0;
          ill_n = 1'b1;
        end
      endcase
  end
  always_comb begin
    state_n       = state;
    bus.in_ready  = state == IDLE;
    bus.out_valid = state == DONE;
    bus.busy      = state != IDLE;
    case (state)
      IDLE:    state_n = accept ? BUSY : IDLE;
      BUSY:    state_n = !is_sb || last ? DONE : BUSY;
      DONE:    state_n = bus.out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= OP_XOR;
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
      ill_q <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q  <= valu_op'(bus.alu_control);
        a_q   <= bus.op1;
        b_q   <= bus.op2;
        ill_q <= 1'b0;
      end
      if (state == BUSY) begin
        r_q   <= res_n;
        ill_q <= ill_n;
        if (is_sb) cnt <= last ? '0 : cnt + 1'b1;
      end
    end
  end
endmodule
